// File: rtl/ub_dequant_reader_if.sv
// ub_dequant_reader_if: bundles the unified-buffer read port and the
// dequantized output stream (valid/ready, data, last) of ub_dequant_reader.
// master = the reader block, slave = UB memory + downstream consumer side.
interface ub_dequant_reader_if #(
    parameter int ADDR_W = 10
) ();
    logic              ub_rd_en;
    logic [ADDR_W-1:0] ub_rd_addr;
    logic [7:0]        ub_rd_data;
    logic              valid_out;
    logic              ready_in;
    logic [31:0]       data_out;
    logic              last_out;

    modport master (
        output ub_rd_en,
        output ub_rd_addr,
        input  ub_rd_data,
        output valid_out,
        input  ready_in,
        output data_out,
        output last_out
    );

    modport slave (
        input  ub_rd_en,
        input  ub_rd_addr,
        output ub_rd_data,
        input  valid_out,
        output ready_in,
        input  data_out,
        input  last_out
    );
endinterface

// File: rtl/ub_dequant_reader.sv
// ub_dequant_reader: reads `length` int8 elements from the unified buffer,
// dequantizes each as round((q - zp) * S / 256) with S in signed Q8.8, and
// streams 32-bit signed results through a show-ahead FIFO. Reads are
// credit-limited to FIFO_DEPTH outstanding elements so the FIFO never
// overflows. Optional feature macro: UB_READ_STRIDE_EN (adds rd_stride,
// the per-read address increment; otherwise the stride is 1).
module ub_dequant_reader #(
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 11,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [15:0]       dq_scale,
    input  logic [7:0]        dq_zero_point,
`ifdef UB_READ_STRIDE_EN
    input  logic [ADDR_W-1:0] rd_stride,
`endif
    output logic              busy,
    output logic              done,
    ub_dequant_reader_if.master bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // control state
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [15:0]       r_scale;
    logic [7:0]        r_zp;
    logic [CW-1:0]     r_credits;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;

    // datapath pipeline
    logic              r_v1;
    logic              r_last1;
    logic [8:0]        r_d;
    logic              r_vd;
    logic              r_lastd;
    logic [24:0]       r_p;
    logic              r_vp;
    logic              r_lastp;

    // output FIFO: {last, data}
    logic [32:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic [1:0]        w_state_nxt;
    logic [CW-1:0]     w_credits_nxt;
    logic              w_done_nxt;
    logic              w_rd_en_nxt;
    logic              w_accept;
    logic              w_issue;
    logic              w_pop;
    logic              w_push;
    logic              w_drained;
    logic [ADDR_W-1:0] w_stride;
    logic [8:0]        w_d;
    logic [24:0]       w_d_ext;
    logic [24:0]       w_s_ext;
    logic [24:0]       w_p;
    logic [24:0]       w_rnd;
    logic [31:0]       w_result;
    logic              w_valid;

`ifdef UB_READ_STRIDE_EN
    logic [ADDR_W-1:0] r_stride;
    assign w_stride = r_stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    assign w_accept  = (r_state == ST_IDLE) && start && (length != LEN_W'(0));
    assign w_issue   = r_rd_en;
    assign w_valid   = (r_count != CW'(0));
    assign w_pop     = w_valid && bus.ready_in;
    assign w_push    = r_vp;
    assign w_drained = !r_v1 && !r_vd && !r_vp && (r_count == CW'(0)) && (r_credits == CW'(0));

    // next-state, done and credit computation; ub_rd_en is precomputed one cycle ahead
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length != LEN_W'(0)) begin
                        w_state_nxt = ST_READ;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (w_issue && (r_remaining == LEN_W'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        case ({w_issue, w_pop})
            2'b10:   w_credits_nxt = r_credits + CW'(1);
            2'b01:   w_credits_nxt = r_credits - CW'(1);
            default: w_credits_nxt = r_credits;
        endcase

        w_rd_en_nxt = (w_state_nxt == ST_READ) && (w_credits_nxt < CW'(FIFO_DEPTH));
    end

    // control registers: FSM, command latch, address/length counters, credits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_scale     <= 16'd0;
            r_zp        <= 8'd0;
            r_credits   <= '0;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef UB_READ_STRIDE_EN
            r_stride    <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_credits <= w_credits_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_done_nxt;
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= length;
                r_scale     <= dq_scale;
                r_zp        <= dq_zero_point;
`ifdef UB_READ_STRIDE_EN
                r_stride    <= rd_stride;
`endif
            end else if (w_issue) begin
                r_addr      <= r_addr + w_stride;
                r_remaining <= r_remaining - LEN_W'(1);
            end else begin
                r_addr      <= r_addr;
                r_remaining <= r_remaining;
            end
        end
    end

    // dequant arithmetic: 9-bit difference, 25-bit product, round-half-up shift
    assign w_d      = {bus.ub_rd_data[7], bus.ub_rd_data} - {r_zp[7], r_zp};
    assign w_d_ext  = {{16{r_d[8]}}, r_d};
    assign w_s_ext  = {{9{r_scale[15]}}, r_scale};
    assign w_p      = w_d_ext * w_s_ext;
    assign w_rnd    = r_p + 25'd128;
    assign w_result = {{15{w_rnd[24]}}, w_rnd[24:8]};

    // three-stage dequant pipeline with valid and last tags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_d     <= 9'd0;
            r_vd    <= 1'b0;
            r_lastd <= 1'b0;
            r_p     <= 25'd0;
            r_vp    <= 1'b0;
            r_lastp <= 1'b0;
        end else begin
            r_v1    <= w_issue;
            r_last1 <= w_issue && (r_remaining == LEN_W'(1));
            r_d     <= w_d;
            r_vd    <= r_v1;
            r_lastd <= r_last1;
            r_p     <= w_p;
            r_vp    <= r_vd;
            r_lastp <= r_lastd;
        end
    end

    // FIFO storage write; contents need no reset since outputs are gated by valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wptr] <= {r_lastp, w_result};
        end else begin
            r_fifo_mem[r_wptr] <= r_fifo_mem[r_wptr];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end else begin
                r_rptr <= r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign bus.ub_rd_en   = r_rd_en;
    assign bus.ub_rd_addr = r_addr;
    assign bus.valid_out  = w_valid;
    assign bus.data_out   = w_valid ? r_fifo_mem[r_rptr][31:0] : 32'd0;
    assign bus.last_out   = w_valid ? r_fifo_mem[r_rptr][32] : 1'b0;

endmodule

// File: tb/tb_ub_dequant_reader.sv
// Directed self-checking bench for ub_dequant_reader: UB memory model with
// one-cycle read latency, handshake/read/done monitors, and hand-computed
// expected dequantized values.
module tb_ub_dequant_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [15:0] dq_scale;
    logic [7:0]  dq_zero_point;
    logic [9:0]  rd_stride;
    logic        busy;
    logic        done;

    ub_dequant_reader_if #(.ADDR_W(10)) bus ();

    ub_dequant_reader #(.ADDR_W(10), .LEN_W(11), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .dq_scale      (dq_scale),
        .dq_zero_point (dq_zero_point),
`ifdef UB_READ_STRIDE_EN
        .rd_stride     (rd_stride),
`endif
        .busy          (busy),
        .done          (done),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ub_mem [0:1023];
    logic [31:0] out_data [0:511];
    logic        out_last [0:511];
    logic [9:0]  rd_addr_log [0:511];
    int          out_n = 0;
    int          rd_total = 0;
    int          done_total = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    // UB model: data valid one cycle after the read enable
    always @(posedge clk) begin
        if (bus.ub_rd_en) bus.ub_rd_data <= ub_mem[bus.ub_rd_addr];
    end

    // record issued reads, output handshakes and done pulses
    always @(posedge clk) begin
        if (bus.ub_rd_en) begin
            rd_addr_log[rd_total] <= bus.ub_rd_addr;
            rd_total <= rd_total + 1;
        end
        if (bus.valid_out && bus.ready_in) begin
            out_data[out_n] <= bus.data_out;
            out_last[out_n] <= bus.last_out;
            out_n <= out_n + 1;
        end
        if (done) done_total <= done_total + 1;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [9:0] b, input logic [10:0] l, input logic [15:0] s, input logic [7:0] z);
        base_addr     = b;
        length        = l;
        dq_scale      = s;
        dq_zero_point = z;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 400 && done_total == d0; i++) tick();
        chk_val(tag, 32'(done_total - d0), 32'd1);
    endtask

    task automatic chk_out(input string tag, input int idx, input int exp, input logic exp_last);
        chk_val($sformatf("%s_val%0d", tag, idx), out_data[idx], 32'(exp));
        chk_val($sformatf("%s_last%0d", tag, idx), 32'(out_last[idx]), 32'(exp_last));
    endtask

    int exp1 [4] = '{5, -7, 127, -128};
    int exp4 [4] = '{10, -1, 5, -7};
    int adr4 [4] = '{1022, 1023, 0, 1};
    int exp6 [4] = '{20, -20, 100, -100};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int o0, r0, d0;
        for (int i = 0; i < 1024; i++) ub_mem[i] = 8'd0;
        reset = 1'b1; start = 1'b0; base_addr = 10'd0; length = 11'd0;
        dq_scale = 16'h0100; dq_zero_point = 8'd0; rd_stride = 10'd1;
        bus.ready_in = 1'b0;
        tick(); tick(); tick();
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_done", 32'(done), 32'd0);
        chk_val("rst_rd_en", 32'(bus.ub_rd_en), 32'd0);
        chk_val("rst_valid", 32'(bus.valid_out), 32'd0);
        chk_val("rst_data", bus.data_out, 32'd0);
        reset = 1'b0;
        tick();

        // 1: identity mapping, latency, last tag
        ub_mem[0] = 8'd5; ub_mem[1] = 8'hF9; ub_mem[2] = 8'd127; ub_mem[3] = 8'h80;
        bus.ready_in = 1'b1;
        o0 = out_n; r0 = rd_total; d0 = done_total;
        start_cmd(10'd0, 11'd4, 16'h0100, 8'd0);
        chk_val("t1_rd_en_c1", 32'(bus.ub_rd_en), 32'd1);
        chk_val("t1_busy_c1", 32'(busy), 32'd1);
        tick(); tick(); tick();
        chk_val("t1_valid_c4", 32'(bus.valid_out), 32'd0);
        tick();
        chk_val("t1_valid_c5", 32'(bus.valid_out), 32'd1);
        chk_val("t1_data_c5", bus.data_out, 32'd5);
        wait_done("t1_done", d0);
        tick(); tick(); tick();
        chk_val("t1_done_once", 32'(done_total - d0), 32'd1);
        chk_val("t1_nout", 32'(out_n - o0), 32'd4);
        chk_val("t1_nrd", 32'(rd_total - r0), 32'd4);
        chk_val("t1_busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) chk_out("t1", o0 + i, exp1[i], (i == 3));

        // 2: rounding cases
        ub_mem[0] = 8'd7;
        o0 = out_n; d0 = done_total;
        start_cmd(10'd0, 11'd1, 16'h0080, 8'hFD);
        wait_done("t2a_done", d0);
        chk_out("t2a", o0, 5, 1'b1);
        ub_mem[0] = 8'h80;
        o0 = out_n; d0 = done_total;
        start_cmd(10'd0, 11'd1, 16'h7FFF, 8'd127);
        wait_done("t2b_done", d0);
        chk_out("t2b", o0, -32639, 1'b1);
        ub_mem[0] = 8'd1;
        o0 = out_n; d0 = done_total;
        start_cmd(10'd0, 11'd1, 16'h0080, 8'd0);
        wait_done("t2c_done", d0);
        chk_out("t2c", o0, 1, 1'b1);
        ub_mem[0] = 8'd5;

        // 3: backpressure, credit limit of 8, out = q - 2
        for (int i = 0; i < 16; i++) ub_mem[16 + i] = 8'(i * 9 - 70);
        bus.ready_in = 1'b0;
        o0 = out_n; r0 = rd_total; d0 = done_total;
        start_cmd(10'd16, 11'd16, 16'h0100, 8'd2);
        for (int i = 0; i < 20; i++) tick();
        chk_val("t3_rd_before_pop", 32'(rd_total - r0), 32'd8);
        chk_val("t3_out_before_pop", 32'(out_n - o0), 32'd0);
        chk_val("t3_valid_held", 32'(bus.valid_out), 32'd1);
        bus.ready_in = 1'b1;
        wait_done("t3_done", d0);
        chk_val("t3_nout", 32'(out_n - o0), 32'd16);
        chk_val("t3_nrd", 32'(rd_total - r0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk_out("t3", o0 + i, i * 9 - 72, (i == 15));
            chk_val($sformatf("t3_addr%0d", i), 32'(rd_addr_log[r0 + i]), 32'(16 + i));
        end

        // 4a: zero length
        r0 = rd_total; d0 = done_total;
        start_cmd(10'd5, 11'd0, 16'h0100, 8'd0);
        chk_val("t4a_done_c1", 32'(done), 32'd1);
        chk_val("t4a_busy_c1", 32'(busy), 32'd0);
        tick();
        chk_val("t4a_done_c2", 32'(done), 32'd0);
        tick(); tick();
        chk_val("t4a_nrd", 32'(rd_total - r0), 32'd0);

        // 4b: address wrap
        ub_mem[1022] = 8'd10; ub_mem[1023] = 8'hFF; ub_mem[0] = 8'd5; ub_mem[1] = 8'hF9;
        o0 = out_n; r0 = rd_total; d0 = done_total;
        start_cmd(10'd1022, 11'd4, 16'h0100, 8'd0);
        wait_done("t4b_done", d0);
        chk_val("t4b_nout", 32'(out_n - o0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk_out("t4b", o0 + i, exp4[i], (i == 3));
            chk_val($sformatf("t4b_addr%0d", i), 32'(rd_addr_log[r0 + i]), 32'(adr4[i]));
        end

        // 5: reset mid-transfer
        ub_mem[100] = 8'd33; ub_mem[101] = 8'hD4;
        o0 = out_n; d0 = done_total;
        start_cmd(10'd100, 11'd8, 16'h0100, 8'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk_val("t5_busy", 32'(busy), 32'd0);
        chk_val("t5_done", 32'(done), 32'd0);
        chk_val("t5_rd_en", 32'(bus.ub_rd_en), 32'd0);
        chk_val("t5_addr", 32'(bus.ub_rd_addr), 32'd0);
        chk_val("t5_valid", 32'(bus.valid_out), 32'd0);
        chk_val("t5_data", bus.data_out, 32'd0);
        chk_val("t5_last", 32'(bus.last_out), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk_val("t5_no_done", 32'(done_total - d0), 32'd0);
        chk_val("t5_no_stale", 32'(out_n - o0), 32'd0);
        d0 = done_total;
        start_cmd(10'd100, 11'd2, 16'h0100, 8'd0);
        wait_done("t5_done2", d0);
        chk_val("t5_nout", 32'(out_n - o0), 32'd2);
        chk_out("t5", o0, 33, 1'b0);
        chk_out("t5", o0 + 1, -44, 1'b1);

        // 6: config isolation and start while busy
        ub_mem[200] = 8'd20; ub_mem[201] = 8'hEC; ub_mem[202] = 8'd100; ub_mem[203] = 8'h9C;
        o0 = out_n; r0 = rd_total; d0 = done_total;
        start_cmd(10'd200, 11'd4, 16'h0100, 8'd0);
        start_cmd(10'd0, 11'd5, 16'h0300, 8'd50);
        wait_done("t6_done", d0);
        for (int i = 0; i < 10; i++) tick();
        chk_val("t6_done_once", 32'(done_total - d0), 32'd1);
        chk_val("t6_nrd", 32'(rd_total - r0), 32'd4);
        chk_val("t6_nout", 32'(out_n - o0), 32'd4);
        for (int i = 0; i < 4; i++) chk_out("t6", o0 + i, exp6[i], (i == 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
